// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - shared state encoding and BCD constants for the microwave timer
package microwave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTING = 3'd1,
        ST_COOKING = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam logic [3:0] BCD_MAX_DIGIT   = 4'd9;
    localparam logic [3:0] SEC_TENS_RELOAD = 4'd5;

    function automatic logic key_is_digit(input logic [3:0] d);
        return d <= BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_countdown.sv
// rtl/bcd_countdown.sv - combinational one-second decrement of an M:TS time plus zero detect
module bcd_countdown
    import microwave_pkg::*;
(
    input  logic [3:0] i_min,
    input  logic [3:0] i_ten,
    input  logic [3:0] i_sec,
    output logic [3:0] o_min,
    output logic [3:0] o_ten,
    output logic [3:0] o_sec,
    output logic       o_zero
);

    always_comb begin
        o_min  = i_min;
        o_ten  = i_ten;
        o_sec  = i_sec;
        o_zero = ~|{i_min, i_ten, i_sec};
        if (i_sec != 4'd0) begin
            o_sec = i_sec - 4'd1;
        end else if (i_ten != 4'd0) begin
            o_ten = i_ten - 4'd1;
            o_sec = BCD_MAX_DIGIT;
        end else if (i_min != 4'd0) begin
            o_min = i_min - 4'd1;
            o_ten = SEC_TENS_RELOAD;
            o_sec = BCD_MAX_DIGIT;
        end
        // 0:00 maps to itself so the countdown can never wrap
    end

endmodule

// File: rtl/microwave_timer_ctrl.sv
// rtl/microwave_timer_ctrl.sv - keypad entry, 1 s BCD countdown and magnetron/done control
module microwave_timer_ctrl
    import microwave_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       KeyValid,
    input  logic [3:0] KeyDigit,
    input  logic       Start,
    input  logic       StopClear,
    input  logic       DoorClosed,
    output logic [3:0] Minutes,
    output logic [3:0] TenSec,
    output logic [3:0] Sec,
    output logic       MagOn,
    output logic       Done
);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    state_e           r_state, w_state_nxt;
    logic [3:0]       r_min, r_ten, r_sec;
    logic [3:0]       w_min_nxt, w_ten_nxt, w_sec_nxt;
    logic [CNT_W-1:0] r_presc, w_presc_nxt;

    logic [3:0] w_dec_min, w_dec_ten, w_dec_sec;
    logic       w_time_zero, w_dec_zero, w_tick, w_key_ok;

    bcd_countdown u_countdown (
        .i_min  (r_min),
        .i_ten  (r_ten),
        .i_sec  (r_sec),
        .o_min  (w_dec_min),
        .o_ten  (w_dec_ten),
        .o_sec  (w_dec_sec),
        .o_zero (w_time_zero)
    );

    assign w_dec_zero = ~|{w_dec_min, w_dec_ten, w_dec_sec};
    assign w_tick     = (r_presc == TICK_LAST);
    assign w_key_ok   = KeyValid && key_is_digit(KeyDigit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_min   <= 4'd0;
            r_ten   <= 4'd0;
            r_sec   <= 4'd0;
            r_presc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_min   <= w_min_nxt;
            r_ten   <= w_ten_nxt;
            r_sec   <= w_sec_nxt;
            r_presc <= w_presc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_min_nxt   = r_min;
        w_ten_nxt   = r_ten;
        w_sec_nxt   = r_sec;
        w_presc_nxt = r_presc;
        case (r_state)
            ST_IDLE, ST_SETTING: begin
                if (StopClear) begin
                    w_state_nxt = ST_IDLE;
                    w_min_nxt   = 4'd0;
                    w_ten_nxt   = 4'd0;
                    w_sec_nxt   = 4'd0;
                end else if (r_state == ST_SETTING && Start && DoorClosed && !w_time_zero) begin
                    w_state_nxt = ST_COOKING;
                    w_presc_nxt = '0;
                end else if (w_key_ok) begin
                    w_state_nxt = ST_SETTING;
                    w_min_nxt   = r_ten;
                    w_ten_nxt   = r_sec;
                    w_sec_nxt   = KeyDigit;
                end
            end
            ST_COOKING: begin
                // Pausing drops the pending tick and freezes the prescaler where it is
                if (StopClear || !DoorClosed) begin
                    w_state_nxt = ST_PAUSED;
                end else if (w_tick) begin
                    w_presc_nxt = '0;
                    w_min_nxt   = w_dec_min;
                    w_ten_nxt   = w_dec_ten;
                    w_sec_nxt   = w_dec_sec;
                    if (w_dec_zero) begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_presc_nxt = r_presc + 1'b1;
                end
            end
            ST_PAUSED: begin
                if (StopClear) begin
                    w_state_nxt = ST_IDLE;
                    w_min_nxt   = 4'd0;
                    w_ten_nxt   = 4'd0;
                    w_sec_nxt   = 4'd0;
                end else if (Start && DoorClosed) begin
                    w_state_nxt = ST_COOKING;
                    w_presc_nxt = '0;
                end
            end
            ST_DONE: begin
                if (StopClear || !DoorClosed) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_min_nxt   = 4'd0;
                w_ten_nxt   = 4'd0;
                w_sec_nxt   = 4'd0;
                w_presc_nxt = '0;
            end
        endcase
    end

    assign Minutes = r_min;
    assign TenSec  = r_ten;
    assign Sec     = r_sec;
    assign MagOn   = (r_state == ST_COOKING) && DoorClosed;
    assign Done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// tb/tb_microwave_timer_ctrl.sv - scoreboard bench for microwave_timer_ctrl with TICK_DIV=4
module tb_microwave_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       KeyValid = 1'b0;
    logic [3:0] KeyDigit = 4'd0;
    logic       Start = 1'b0;
    logic       StopClear = 1'b0;
    logic       DoorClosed = 1'b1;
    logic [3:0] Minutes, TenSec, Sec;
    logic       MagOn, Done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [13:0] exp;
    } exp_t;

    exp_t sb_q[$];

    logic [13:0] w_obs;
    assign w_obs = {Minutes, TenSec, Sec, MagOn, Done};

    microwave_timer_ctrl #(.TICK_DIV(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .KeyValid   (KeyValid),
        .KeyDigit   (KeyDigit),
        .Start      (Start),
        .StopClear  (StopClear),
        .DoorClosed (DoorClosed),
        .Minutes    (Minutes),
        .TenSec     (TenSec),
        .Sec        (Sec),
        .MagOn      (MagOn),
        .Done       (Done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d:%0d%0d mag=%0b done=%0b, expected %0d:%0d%0d mag=%0b done=%0b",
                     tag, obs[13:10], obs[9:6], obs[5:2], obs[1], obs[0],
                     exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [13:0] pk_d(input int m, input int t, input int s, input logic mag, input logic dn);
        return {4'(m), 4'(t), 4'(s), mag, dn};
    endfunction

    function automatic logic [13:0] pk_s(input int secs, input logic mag, input logic dn);
        return pk_d(secs / 60, (secs % 60) / 10, secs % 10, mag, dn);
    endfunction

    // Drive one cycle of inputs and queue what the outputs must show after the next edge
    task automatic cyc(input logic kv, input logic [3:0] kd, input logic st, input logic sc,
                       input logic dc, input logic [13:0] exp, input string tag);
        KeyValid   = kv;
        KeyDigit   = kd;
        Start      = st;
        StopClear  = sc;
        DoorClosed = dc;
        sb_q.push_back('{tag, exp});
        @(negedge clk);
    endtask

    always @(posedge clk) begin : sampler
        exp_t e;
        #1;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, w_obs, e.exp);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset", w_obs, 14'd0);
        rst_n = 1'b1;

        // 1:30 countdown
        cyc(1, 4'd1, 0, 0, 1, pk_d(0, 0, 1, 0, 0), "key1");
        cyc(1, 4'd3, 0, 0, 1, pk_d(0, 1, 3, 0, 0), "key3");
        cyc(1, 4'd0, 0, 0, 1, pk_d(1, 3, 0, 0, 0), "key0");
        cyc(0, 4'd0, 1, 0, 1, pk_s(90, 1, 0), "start_130");
        for (int i = 1; i <= 8; i++)
            cyc(0, 4'd0, 0, 0, 1, pk_s(90 - i / 4, 1, 0), "run_130");
        cyc(0, 4'd0, 0, 1, 1, pk_s(88, 0, 0), "stop_pause");
        cyc(0, 4'd0, 0, 1, 1, pk_s(0, 0, 0), "stop_clear");

        // 0:10 to expiry
        cyc(1, 4'd1, 0, 0, 1, pk_d(0, 0, 1, 0, 0), "key1b");
        cyc(1, 4'd0, 0, 0, 1, pk_d(0, 1, 0, 0, 0), "key0b");
        cyc(0, 4'd0, 1, 0, 1, pk_s(10, 1, 0), "start_010");
        for (int i = 1; i <= 40; i++) begin
            int secs;
            secs = 10 - i / 4;
            cyc(0, 4'd0, 0, 0, 1, pk_s(secs, secs != 0, secs == 0), "run_010");
        end
        cyc(1, 4'd5, 1, 0, 1, pk_s(0, 0, 1), "done_ignores_key");
        cyc(0, 4'd0, 0, 1, 1, pk_s(0, 0, 0), "done_clear");

        // 1:00 borrow
        cyc(1, 4'd1, 0, 0, 1, pk_d(0, 0, 1, 0, 0), "key1c");
        cyc(1, 4'd0, 0, 0, 1, pk_d(0, 1, 0, 0, 0), "key0c");
        cyc(1, 4'd0, 0, 0, 1, pk_d(1, 0, 0, 0, 0), "key0d");
        cyc(0, 4'd0, 1, 0, 1, pk_s(60, 1, 0), "start_100");
        for (int i = 1; i <= 4; i++)
            cyc(0, 4'd0, 0, 0, 1, pk_s(60 - i / 4, 1, 0), "borrow");
        cyc(0, 4'd0, 0, 1, 1, pk_s(59, 0, 0), "stop_pause2");
        cyc(0, 4'd0, 0, 1, 1, pk_s(0, 0, 0), "stop_clear2");

        // door open mid-prescaler at 0:45
        cyc(1, 4'd4, 0, 0, 1, pk_d(0, 0, 4, 0, 0), "key4");
        cyc(1, 4'd5, 0, 0, 1, pk_d(0, 4, 5, 0, 0), "key5");
        cyc(0, 4'd0, 1, 0, 1, pk_s(45, 1, 0), "start_045");
        cyc(0, 4'd0, 0, 0, 1, pk_s(45, 1, 0), "run_045a");
        cyc(0, 4'd0, 0, 0, 1, pk_s(45, 1, 0), "run_045b");
        DoorClosed = 1'b0;
        #1;
        check_eq("mag_door_drop", {13'd0, MagOn}, 14'd0);
        cyc(0, 4'd0, 0, 0, 0, pk_s(45, 0, 0), "pause_door");
        for (int i = 0; i < 3; i++)
            cyc(0, 4'd0, 0, 0, 0, pk_s(45, 0, 0), "frozen");
        cyc(1, 4'd8, 1, 0, 0, pk_s(45, 0, 0), "paused_ignores");
        cyc(0, 4'd0, 1, 0, 1, pk_s(45, 1, 0), "resume");
        for (int i = 1; i <= 4; i++)
            cyc(0, 4'd0, 0, 0, 1, pk_s(45 - i / 4, 1, 0), "resume_run");
        cyc(0, 4'd0, 0, 1, 1, pk_s(44, 0, 0), "stop_pause3");
        cyc(0, 4'd0, 0, 1, 1, pk_s(0, 0, 0), "stop_clear3");

        // invalid key, open-door start, StopClear beats Start
        cyc(1, 4'd5, 0, 0, 1, pk_d(0, 0, 5, 0, 0), "key5b");
        cyc(1, 4'd12, 0, 0, 1, pk_d(0, 0, 5, 0, 0), "bad_key");
        cyc(0, 4'd0, 1, 0, 0, pk_d(0, 0, 5, 0, 0), "start_door_open");
        cyc(1, 4'd2, 0, 0, 1, pk_d(0, 5, 2, 0, 0), "still_setting");
        cyc(0, 4'd0, 1, 1, 1, pk_s(0, 0, 0), "sc_beats_start");
        cyc(0, 4'd0, 1, 0, 1, pk_s(0, 0, 0), "start_idle_zero");

        // asynchronous reset while cooking
        cyc(1, 4'd3, 0, 0, 1, pk_d(0, 0, 3, 0, 0), "key3b");
        cyc(0, 4'd0, 1, 0, 1, pk_s(3, 1, 0), "start_003");
        cyc(0, 4'd0, 0, 0, 1, pk_s(3, 1, 0), "run_003");
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset", w_obs, 14'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 4'd7, 0, 0, 1, pk_d(0, 0, 7, 0, 0), "key7_after_rst");
        cyc(0, 4'd0, 1, 0, 1, pk_s(7, 1, 0), "start_007");

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/microwave_timer_ctrl.md
Name: microwave_timer_ctrl

Overview:
Timer controller for the microwave front panel. It accepts keypad digits, holds the cook time as three BCD digits (minutes, tens of seconds, seconds) and counts it down once per second while cooking. It drives the magnetron enable and a done flag. Its BCD digit outputs feed the seven-segment decoder (Minutes/TenSec/Sec inputs) directly.

Parameters:
TICK_DIV, 50000000, clock cycles per one-second tick; legal values are 2 or more.
CNT_W, 26, prescaler counter width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
clk  input  1  system clock; the only clock in the block.
rst_n  input  1  asynchronous, active-low reset.
KeyValid  input  1  one-cycle strobe: KeyDigit is valid this cycle.
KeyDigit  input  4  keypad digit, BCD 0-9; values 10-15 are ignored.
Start  input  1  start/resume request (level, sampled every cycle).
StopClear  input  1  stop/clear request (level, sampled every cycle).
DoorClosed  input  1  1 = door closed.
Minutes  output  4  BCD minutes digit, to the decoder.
TenSec  output  4  BCD tens-of-seconds digit, to the decoder.
Sec  output  4  BCD seconds digit, to the decoder.
MagOn  output  1  magnetron enable.
Done  output  1  cook-complete flag.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: Minutes=0, TenSec=0, Sec=0, state=IDLE, prescaler=0, MagOn=0, Done=0.
- States: IDLE, SETTING, COOKING, PAUSED, DONE. All transitions are registered.
- Per-cycle priority: StopClear, then door-open, then Start, then tick, then KeyValid.
- IDLE:
  - Digits are 0:00.
  - KeyValid with KeyDigit<=9: shift the digit in and go to SETTING.
- Key shift (IDLE/SETTING only):
  - Minutes<=TenSec, TenSec<=Sec, Sec<=KeyDigit; the old Minutes digit is discarded.
  - TenSec may hold 6-9 (e.g. 1:90 is legal).
- SETTING:
  - StopClear: digits go to 0 and state goes to IDLE.
  - Start with DoorClosed=1 and time != 0:00: go to COOKING and clear the prescaler.
  - Start with the door open or time = 0:00: ignored.
- COOKING:
  - The prescaler counts 0..TICK_DIV-1; the tick fires in the cycle it equals TICK_DIV-1, then it wraps to 0.
  - First decrement lands exactly TICK_DIV cycles after the Start cycle.
  - On a tick the time decrements in BCD:
    - Sec>0: Sec-1.
    - Sec=0 and TenSec>0: TenSec-1, Sec=9.
    - Both 0: Minutes-1, TenSec=5, Sec=9.
  - A tick that takes the time to 0:00 also moves the state to DONE in the same edge.
  - Door opening or StopClear: go to PAUSED. The pending tick is discarded and the prescaler holds.
  - KeyValid and Start are ignored.
- PAUSED:
  - Start with DoorClosed=1: go to COOKING and clear the prescaler.
  - StopClear: digits go to 0 and state goes to IDLE.
  - Keys are ignored.
- DONE:
  - Digits stay at 0:00 and Done=1.
  - StopClear or door-open: go to IDLE.
  - Start and keys are ignored.
- MagOn = (state==COOKING) AND DoorClosed. This is combinational gating, so the door opening drops MagOn in the same cycle.
- Done = (state==DONE), registered via state.
- Reset mid-COOKING: all outputs return to reset values immediately (asynchronous).
- Digits never exceed 9. The countdown never wraps below 0:00.

Decomposition:
- Package microwave_pkg holds:
  - state encoding constants (3-bit): IDLE, SETTING, COOKING, PAUSED, DONE;
  - BCD_MAX_DIGIT=9 and SEC_TENS_RELOAD=5.
- Sub-module bcd_countdown is natural: a combinational 3-digit BCD decrement plus a zero-detect output. The controller instantiates it once.

Test Plan (TICK_DIV=4):
- Keys 1,3,0 then Start (door closed) -> 1:30 displayed. MagOn=1 the cycle after Start. After 4 cycles 1:29; after 8 cycles 1:28.
- Load 0:10, Start, run to expiry -> sequence 0:09 ... 0:01, 0:00. Done=1 and MagOn=0 on the edge that reaches 0:00. StopClear returns to IDLE with Done=0.
- Load 1:00, Start, one tick -> 0:59 (borrow across both digits).
- COOKING at 0:45, drop DoorClosed mid-prescaler -> MagOn=0 same cycle, state PAUSED, time frozen at 0:45. Close door + Start -> resumes; 0:44 exactly 4 cycles later.
- Keys 5 then 12 (invalid) -> 0:05 only. Start with DoorClosed=0 -> stays SETTING. StopClear+Start same cycle -> IDLE, 0:00.
- Assert rst_n=0 mid-COOKING between clock edges -> outputs 0 immediately. After release, KeyValid=1 with digit 7 -> 0:07, SETTING.
